// File: rtl/reg_operand_fetch_pkg.sv
// reg_opfetch_pkg: shared widths, address/word types and the execute-side output register layout
package reg_opfetch_pkg;
  localparam int WL = 32;
  localparam int AL = 5;
  typedef logic [AL-1:0] reg_addr_t;
  typedef logic [WL-1:0] word_t;
  typedef struct packed {
    word_t     op1;
    word_t     op2;
    reg_addr_t rd;
    logic      wr;
  } opfetch_ex_t;
endpackage

// File: rtl/reg_operand_fetch_if.sv
// reg_operand_fetch_if: decode, register-bank, writeback and execute signals of the operand fetch stage
import reg_opfetch_pkg::*;
interface reg_operand_fetch_if;
  logic      id_valid, id_ready, id_use_rs1, id_use_rs2, id_wr;
  reg_addr_t id_rs1, id_rs2, id_rd;
  logic      rb_rd1_en, rb_rd2_en;
  reg_addr_t rb_r_addr1, rb_r_addr2;
  word_t     rb_r_data1, rb_r_data2;
  logic      wb_valid;
  reg_addr_t wb_addr;
  word_t     wb_data;
  logic      ex_valid, ex_ready, ex_wr;
  word_t     ex_op1, ex_op2;
  reg_addr_t ex_rd;
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wr,
    input  rb_r_data1, rb_r_data2, wb_valid, wb_addr, wb_data, ex_ready,
    output id_ready, rb_rd1_en, rb_rd2_en, rb_r_addr1, rb_r_addr2,
    output ex_valid, ex_op1, ex_op2, ex_rd, ex_wr
  );
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wr,
    output rb_r_data1, rb_r_data2, wb_valid, wb_addr, wb_data, ex_ready,
    input  id_ready, rb_rd1_en, rb_rd2_en, rb_r_addr1, rb_r_addr2,
    input  ex_valid, ex_op1, ex_op2, ex_rd, ex_wr
  );
endinterface

// File: rtl/reg_operand_fetch_scoreboard.sv
// reg_scoreboard: one pending bit per register, set by issued writes, cleared by writeback, set wins
import reg_opfetch_pkg::*;
module reg_scoreboard #(
  parameter int AW = AL
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rd,
  output logic          pend_rs1,
  output logic          pend_rs2,
  output logic          pend_rd
);
  localparam int NREG = 2**AW;
  logic [NREG-1:0] sb, set_m, clr_m, pend;
  assign set_m = set_en ? {{(NREG-1){1'b0}}, 1'b1} << set_addr : '0;
  assign clr_m = clr_en ? {{(NREG-1){1'b0}}, 1'b1} << clr_addr : '0;
  assign pend = sb & ~clr_m;
  assign pend_rs1 = pend[rs1];
  assign pend_rs2 = pend[rs2];
  assign pend_rd = pend[rd];
  // writeback retires a bit before a same-cycle issue re-marks it pending
  always_ff @(posedge clk or posedge rst)
    if (rst) sb <= '0;
    else sb <= pend | set_m;
endmodule

// File: rtl/reg_operand_fetch.sv
// reg_operand_fetch: operand fetch with writeback bypass and hazard scoreboard; REG_OPFETCH_ZERO_REG_EN hardwires r0 to zero
import reg_opfetch_pkg::*;
module reg_operand_fetch (
  input logic               clk,
  input logic               rst,
  reg_operand_fetch_if.slave bus
);
`ifdef REG_OPFETCH_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif
  opfetch_ex_t ex_q;
  logic ex_valid_q, p1, p2, pd, hazard, accept, z1, z2, zd;
  word_t op1, op2;
  assign z1 = ZERO_REG && bus.id_rs1 == '0;
  assign z2 = ZERO_REG && bus.id_rs2 == '0;
  assign zd = ZERO_REG && bus.id_rd == '0;
  assign bus.rb_rd1_en = bus.id_valid & bus.id_use_rs1;
  assign bus.rb_rd2_en = bus.id_valid & bus.id_use_rs2;
  assign bus.rb_r_addr1 = bus.id_rs1;
  assign bus.rb_r_addr2 = bus.id_rs2;
  // bank data is stale for a register being written this cycle, so take it off the writeback bus
  always_comb begin
    op1 = (!bus.id_use_rs1 || z1) ? '0 : (bus.wb_valid && bus.wb_addr == bus.id_rs1) ? bus.wb_data : bus.rb_r_data1;
    op2 = (!bus.id_use_rs2 || z2) ? '0 : (bus.wb_valid && bus.wb_addr == bus.id_rs2) ? bus.wb_data : bus.rb_r_data2;
  end
  assign hazard = (bus.id_use_rs1 & p1) | (bus.id_use_rs2 & p2) | (bus.id_wr & pd);
  assign bus.id_ready = !hazard && (!ex_valid_q || bus.ex_ready);
  assign accept = bus.id_valid && bus.id_ready;
  reg_scoreboard #(.AW(AL)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept && bus.id_wr && !zd),
    .set_addr (bus.id_rd),
    .clr_en   (bus.wb_valid),
    .clr_addr (bus.wb_addr),
    .rs1      (bus.id_rs1),
    .rs2      (bus.id_rs2),
    .rd       (bus.id_rd),
    .pend_rs1 (p1),
    .pend_rs2 (p2),
    .pend_rd  (pd)
  );
  // output register: load on accept, drop valid once consumed, hold while execute stalls
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q <= '0;
    end else if (accept) begin
      ex_valid_q <= 1'b1;
      ex_q <= {op1, op2, bus.id_rd, bus.id_wr};
    end else if (bus.ex_ready) ex_valid_q <= 1'b0;
  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_op1 = ex_q.op1;
  assign bus.ex_op2 = ex_q.op2;
  assign bus.ex_rd = ex_q.rd;
  assign bus.ex_wr = ex_q.wr;
endmodule

// File: tb/tb_reg_operand_fetch.sv
// tb_reg_operand_fetch: directed operand-fetch scenarios checked by a queue-based scoreboard on the execute side
import reg_opfetch_pkg::*;
module tb_reg_operand_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  word_t bank [2**AL];
  opfetch_ex_t exp_q[$];
  reg_operand_fetch_if bus();
  reg_operand_fetch dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // bank read ports are combinational
  assign bus.rb_r_data1 = bank[bus.rb_r_addr1];
  assign bus.rb_r_data2 = bank[bus.rb_r_addr2];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic opfetch_ex_t ex(input word_t a, input word_t b, input reg_addr_t r, input logic w);
    return {a, b, r, w};
  endfunction

  // advance one clock; the bank model commits the writeback that was live at that edge
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.wb_valid) bank[bus.wb_addr] = bus.wb_data;
  endtask

  task automatic drive(input reg_addr_t rs1, input reg_addr_t rs2, input logic u1, input logic u2,
                       input reg_addr_t rd, input logic wr);
    bus.id_valid = 1'b1;
    bus.id_rs1 = rs1;
    bus.id_rs2 = rs2;
    bus.id_use_rs1 = u1;
    bus.id_use_rs2 = u2;
    bus.id_rd = rd;
    bus.id_wr = wr;
  endtask

  task automatic wb(input reg_addr_t a, input word_t d);
    bus.wb_valid = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
  endtask

  // wait (bounded) for id_ready, record the expected execute-side result, then retire the request
  task automatic accept_wait(input string nm, input opfetch_ex_t e, input int exp_w);
    int w = 0;
    @(negedge clk);
    while (!bus.id_ready && w < exp_w + 4) begin
      step();
      w++;
      @(negedge clk);
    end
    check({nm, "_wait"}, w, exp_w);
    if (bus.id_ready) exp_q.push_back(e);
    step();
    bus.id_valid = 1'b0;
  endtask

  task automatic stall(input string nm, input int n);
    repeat (n) begin
      @(negedge clk);
      check(nm, bus.id_ready, 1'b0);
      step();
    end
  endtask

  // execute-side monitor: every completed transfer must match the oldest expected entry
  initial begin
    opfetch_ex_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.ex_valid && bus.ex_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL ex_unexpected: got %0h, want none", {bus.ex_op1, bus.ex_op2, bus.ex_rd, bus.ex_wr});
        end else begin
          e = exp_q.pop_front();
          check("ex_out", {bus.ex_op1, bus.ex_op2, bus.ex_rd, bus.ex_wr}, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end, want end");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2**AL; i++) bank[i] = 32'h1000 + i;
    bank[0] = 32'hFFFF;
    bank[1] = 32'h11;
    bank[2] = 32'h22;
    bus.id_valid = 1'b0;
    bus.id_rs1 = '0;
    bus.id_rs2 = '0;
    bus.id_use_rs1 = 1'b0;
    bus.id_use_rs2 = 1'b0;
    bus.id_rd = '0;
    bus.id_wr = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
    bus.ex_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    check("rst_ex_valid", bus.ex_valid, 1'b0);
    check("rst_ex_regs", {bus.ex_op1, bus.ex_op2, bus.ex_rd, bus.ex_wr}, '0);
    step();
    rst = 1'b0;
    // basic fetch
    drive(1, 2, 1, 1, 3, 1);
    #1;
    check("rd_port", {bus.rb_rd1_en, bus.rb_rd2_en, bus.rb_r_addr1, bus.rb_r_addr2}, {1'b1, 1'b1, 5'd1, 5'd2});
    accept_wait("basic", ex(32'h11, 32'h22, 3, 1), 0);
    @(negedge clk);
    check("latency", bus.ex_valid, 1'b1);
    step();
    // RAW on r3 resolved by same-cycle writeback bypass
    drive(3, 0, 1, 0, 4, 0);
    #1;
    check("rd2_off", bus.rb_rd2_en, 1'b0);
    stall("raw_stall", 2);
    wb(3, 32'hAB);
    accept_wait("raw", ex(32'hAB, 0, 4, 0), 0);
    bus.wb_valid = 1'b0;
    // backpressure
    drive(1, 2, 1, 1, 6, 0);
    accept_wait("bp_a", ex(32'h11, 32'h22, 6, 0), 0);
    bus.ex_ready = 1'b0;
    drive(2, 1, 1, 1, 7, 0);
    repeat (3) begin
      @(negedge clk);
      check("bp_hold", {bus.id_ready, bus.ex_valid, bus.ex_op1, bus.ex_op2, bus.ex_rd},
            {1'b0, 1'b1, 32'h11, 32'h22, 5'd6});
      step();
    end
    bus.ex_ready = 1'b1;
    accept_wait("bp_b", ex(32'h22, 32'h11, 7, 0), 0);
    step();
    @(negedge clk);
    check("ex_drop", bus.ex_valid, 1'b0);
    step();
    // WAW with set/clear collision on r5
    drive(0, 0, 0, 0, 5, 1);
    accept_wait("waw_c", ex(0, 0, 5, 1), 0);
    drive(0, 0, 0, 0, 5, 1);
    wb(5, 32'h5A);
    accept_wait("waw_d", ex(0, 0, 5, 1), 0);
    bus.wb_valid = 1'b0;
    drive(5, 5, 1, 1, 8, 0);
    stall("coll_stall", 2);
    wb(5, 32'h77);
    accept_wait("coll", ex(32'h77, 32'h77, 8, 0), 0);
    bus.wb_valid = 1'b0;
    // asynchronous reset while stalled with r3 pending and execute held
    drive(1, 0, 1, 0, 3, 1);
    accept_wait("pre_rst", ex(32'h11, 0, 3, 1), 0);
    bus.ex_ready = 1'b0;
    drive(3, 0, 1, 0, 9, 0);
    @(negedge clk);
    check("rst_stall", bus.id_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst", {bus.ex_valid, bus.ex_op1, bus.ex_op2, bus.ex_rd, bus.ex_wr}, '0);
    exp_q.delete();
    step();
    rst = 1'b0;
    bus.ex_ready = 1'b1;
    accept_wait("post_rst", ex(32'hAB, 0, 9, 0), 0);
`ifdef REG_OPFETCH_ZERO_REG_EN
    drive(0, 1, 1, 1, 0, 1);
    wb(0, 32'h99);
    accept_wait("zr_a", ex(0, 32'h11, 0, 1), 0);
    bus.wb_valid = 1'b0;
    drive(0, 0, 1, 0, 0, 1);
    accept_wait("zr_b", ex(0, 0, 0, 1), 0);
`else
    drive(0, 1, 1, 1, 0, 1);
    accept_wait("r0_a", ex(32'hFFFF, 32'h11, 0, 1), 0);
    drive(0, 0, 1, 0, 10, 0);
    stall("r0_stall", 1);
    wb(0, 32'h99);
    accept_wait("r0_b", ex(32'h99, 0, 10, 0), 0);
    bus.wb_valid = 1'b0;
`endif
    repeat (3) step();
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
